// File: rtl/ft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ft_pkg
// Description : Shared types and constants for the FT245 host-to-FPGA command
//               receive path (bus FSM states, parser states, frame constants).
// Revision    : 1.0 - initial release
// ============================================================================
package ft_pkg;

    // Bus ownership FSM for the FTDI read side.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        READ = 2'd2,
        REL  = 2'd3
    } bus_state_t;

    // Framed command parser: SYNC, ADDR, D_HI, D_LO, CSUM.
    typedef enum logic [2:0] {
        HUNT = 3'd0,
        CMD  = 3'd1,
        DHI  = 3'd2,
        DLO  = 3'd3,
        CSUM = 3'd4
    } prs_state_t;

    localparam logic [7:0] c_SYNC_BYTE    = 8'hA5;
    localparam logic [7:0] c_ADDR_ENABLE  = 8'h01;
    localparam logic [7:0] c_ADDR_FFT_CFG = 8'h02;

    // Frame checksum: XOR of address and both payload bytes.
    function automatic logic [7:0] frame_csum(
        input logic [7:0] addr,
        input logic [7:0] dhi,
        input logic [7:0] dlo
    );
        return addr ^ dhi ^ dlo;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ft_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : ft_frame_parser
// Description : Byte-stream parser for SYNC/ADDR/D_HI/D_LO/CSUM frames with an
//               inter-byte timeout and a saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ft_frame_parser
    import ft_pkg::*;
#(
    parameter logic [15:0] TIMEOUT   = 16'd60000,
    parameter logic [7:0]  SYNC_BYTE = c_SYNC_BYTE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte,
    output logic        o_cmd_valid,
    output logic [7:0]  o_cmd_addr,
    output logic [15:0] o_cmd_data,
    output logic [7:0]  o_err_cnt
);

    localparam logic [15:0] c_TMO_LAST = TIMEOUT - 16'd1;
    localparam logic [15:0] c_TMO_ONE  = 16'd1;
    localparam logic [7:0]  c_ERR_ONE  = 8'd1;

    prs_state_t  r_state;
    logic [7:0]  r_addr;
    logic [7:0]  r_dhi;
    logic [7:0]  r_dlo;
    logic [15:0] r_tmo;
    logic        r_cmd_valid;
    logic [7:0]  r_cmd_addr;
    logic [15:0] r_cmd_data;
    logic [7:0]  r_err_cnt;

    logic w_tmo_hit;
    logic w_csum_byte;
    logic w_csum_ok;
    logic w_err;

    // A byte arriving on the deadline cycle wins: it restarts the timer.
    assign w_tmo_hit   = (r_state != HUNT) && !i_byte_vld && (r_tmo == c_TMO_LAST);
    assign w_csum_byte = i_byte_vld && (r_state == CSUM);
    assign w_csum_ok   = (frame_csum(r_addr, r_dhi, r_dlo) == i_byte);
    assign w_err       = w_tmo_hit || (w_csum_byte && !w_csum_ok);

    // Inter-byte timer: idle in HUNT, restarted by every accepted byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= 16'd0;
        end else if ((r_state == HUNT) || i_byte_vld || w_tmo_hit) begin
            r_tmo <= 16'd0;
        end else begin
            r_tmo <= r_tmo + c_TMO_ONE;
        end
    end

    // Frame state machine and field capture; a sync byte inside a frame is data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
            r_addr  <= 8'd0;
            r_dhi   <= 8'd0;
            r_dlo   <= 8'd0;
        end else if (w_tmo_hit) begin
            r_state <= HUNT;
        end else if (i_byte_vld) begin
            case (r_state)
                HUNT: if (i_byte == SYNC_BYTE) r_state <= CMD;
                CMD: begin
                    r_addr  <= i_byte;
                    r_state <= DHI;
                end
                DHI: begin
                    r_dhi   <= i_byte;
                    r_state <= DLO;
                end
                DLO: begin
                    r_dlo   <= i_byte;
                    r_state <= CSUM;
                end
                CSUM:    r_state <= HUNT;
                default: r_state <= HUNT;
            endcase
        end
    end

    // Command register-write pulse; address/data hold until the next good frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_valid <= 1'b0;
            r_cmd_addr  <= 8'd0;
            r_cmd_data  <= 16'd0;
        end else begin
            r_cmd_valid <= 1'b0;
            if (w_csum_byte && w_csum_ok) begin
                r_cmd_valid <= 1'b1;
                r_cmd_addr  <= r_addr;
                r_cmd_data  <= {r_dhi, r_dlo};
            end
        end
    end

    // Saturating count of checksum failures and timeouts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
        end else if (w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + c_ERR_ONE;
        end
    end

    assign o_cmd_valid = r_cmd_valid;
    assign o_cmd_addr  = r_cmd_addr;
    assign o_cmd_data  = r_cmd_data;
    assign o_err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: rtl/ft_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module      : ft_cmd_rx
// Description : FT245 synchronous FIFO read side. Owns the bus when the host
//               has data and the writer is idle, drains up to MAX_BURST bytes
//               per ownership and feeds them to the frame parser.
// Revision    : 1.0 - initial release
// ============================================================================
module ft_cmd_rx
    import ft_pkg::*;
#(
    parameter int          MAX_BURST = 64,
    parameter logic [15:0] TIMEOUT   = 16'd60000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        CLK,
    input  logic        rstn,
    input  logic [7:0]  data_in,
    input  logic        RXF_N,
    output logic        OE_N,
    output logic        RD_N,
    input  logic        tx_busy,
    output logic        rx_active,
    output logic        cmd_valid,
    output logic [7:0]  cmd_addr,
    output logic [15:0] cmd_data,
    output logic [7:0]  err_cnt
);

    localparam int             c_BW         = $clog2(MAX_BURST + 1);
    localparam logic [c_BW-1:0] c_BURST_LAST = c_BW'(MAX_BURST - 1);
    localparam logic [c_BW-1:0] c_BURST_ONE  = c_BW'(1);

    bus_state_t      r_state;
    logic            r_oe_n;
    logic            r_rd_n;
    logic            r_rx_active;
    logic [c_BW-1:0] r_burst_cnt;

    logic w_byte_vld;

    // A byte is transferred on any edge where the strobe is low and the FIFO is non-empty.
    assign w_byte_vld = (r_state == READ) && !RXF_N && !r_rd_n;

    // Bus ownership FSM; tx_busy has priority over pending host data.
    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_oe_n      <= 1'b1;
            r_rd_n      <= 1'b1;
            r_rx_active <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!RXF_N && !tx_busy) begin
                        r_state     <= ACQ;
                        r_oe_n      <= 1'b0;
                        r_rx_active <= 1'b1;
                    end
                end
                ACQ: begin
                    // One turnaround cycle with OE_N low before strobing.
                    r_state <= READ;
                    r_rd_n  <= 1'b0;
                end
                READ: begin
                    if (RXF_N || (w_byte_vld && (r_burst_cnt == c_BURST_LAST))) begin
                        r_state     <= REL;
                        r_oe_n      <= 1'b1;
                        r_rd_n      <= 1'b1;
                        r_rx_active <= 1'b0;
                    end
                end
                REL:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Bytes read in the current ownership; cleared on release.
    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            r_burst_cnt <= '0;
        end else if (r_state == REL) begin
            r_burst_cnt <= '0;
        end else if (w_byte_vld) begin
            r_burst_cnt <= r_burst_cnt + c_BURST_ONE;
        end
    end

    ft_frame_parser #(
        .TIMEOUT   (TIMEOUT),
        .SYNC_BYTE (SYNC_BYTE)
    ) u_parser (
        .clk         (CLK),
        .rst_n       (rstn),
        .i_byte_vld  (w_byte_vld),
        .i_byte      (data_in),
        .o_cmd_valid (cmd_valid),
        .o_cmd_addr  (cmd_addr),
        .o_cmd_data  (cmd_data),
        .o_err_cnt   (err_cnt)
    );

    assign OE_N      = r_oe_n;
    assign RD_N      = r_rd_n;
    assign rx_active = r_rx_active;

endmodule
`default_nettype wire
